// File: rtl/ccff_pkg.sv
// Shared configuration-chain definitions: loader state encoding and default
// bitstream geometry so tile generators and the loader agree.
package ccff_pkg;

    localparam int unsigned CCFF_WORD_W    = 32;
    localparam int unsigned CCFF_CHAIN_LEN = 1024;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_CHECK,
        ST_DONE,
        ST_FAIL
    } ccff_ld_state_t;

endpackage

// File: rtl/ccff_word_serializer.sv
// MSB-first word serializer; bit_out is a register so it can drive ccff_head
// directly and holds its last value while the serializer is empty.
module ccff_word_serializer
    import ccff_pkg::*;
#(
    parameter int unsigned WORD_W = CCFF_WORD_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              load,
    input  logic [WORD_W-1:0] word,
    input  logic              shift,
    output logic              bit_out,
    output logic              empty,
    output logic              last
);

    localparam int unsigned IDX_W = $clog2(WORD_W);

    logic [WORD_W-1:0] word_q, word_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              empty_q, empty_d;
    logic              bit_q, bit_d;

    // Clear beats load; a load may coincide with the last bit shifting out.
    always_comb begin
        word_d  = word_q;
        idx_d   = idx_q;
        empty_d = empty_q;
        bit_d   = bit_q;
        if (clear) begin
            empty_d = 1'b1;
        end else if (load) begin
            word_d  = word;
            idx_d   = IDX_W'(WORD_W - 1);
            empty_d = 1'b0;
            bit_d   = word[WORD_W-1];
        end else if (shift && !empty_q) begin
            if (idx_q == '0) begin
                empty_d = 1'b1;
            end else begin
                idx_d = idx_q - IDX_W'(1);
                bit_d = word_q[idx_q - IDX_W'(1)];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_q  <= '0;
            idx_q   <= '0;
            empty_q <= 1'b1;
            bit_q   <= 1'b0;
        end else begin
            word_q  <= word_d;
            idx_q   <= idx_d;
            empty_q <= empty_d;
            bit_q   <= bit_d;
        end
    end

    assign bit_out = bit_q;
    assign empty   = empty_q;
    assign last    = !empty_q && (idx_q == '0);

endmodule

// File: rtl/ccff_chain_loader.sv
// Configuration-chain loader: streams bitstream words into ccff_head, gates
// the chain clock on underrun and checks the first bit arrives at ccff_tail.
module ccff_chain_loader
    import ccff_pkg::*;
#(
    parameter int unsigned WORD_W    = CCFF_WORD_W,
    parameter int unsigned CHAIN_LEN = CCFF_CHAIN_LEN
) (
    input  logic              prog_clk,
    input  logic              pReset_n,
    input  logic              start,
    input  logic              abort,
    input  logic [WORD_W-1:0] bs_data,
    input  logic              bs_valid,
    output logic              bs_ready,
    output logic              ccff_head,
    input  logic              ccff_tail,
    output logic              prog_clk_en,
    output logic              config_enable,
    output logic              busy,
    output logic              done,
    output logic              fail
);

    localparam int unsigned     CNT_W    = $clog2(CHAIN_LEN + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(CHAIN_LEN);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CHAIN_LEN - 1);

    ccff_ld_state_t   state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             first_bit_q, first_bit_d;
    logic             prog_clk_en_q, prog_clk_en_d;
    logic             config_enable_q, config_enable_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             fail_q, fail_d;

    logic             shift;
    logic             ser_clear;
    logic             ser_load;
    logic             ser_bit;
    logic             ser_empty;
    logic             ser_last;
    logic             ser_busy_next;

    // The registered enable is the single source of truth for a chain shift.
    assign shift = prog_clk_en_q;

    ccff_word_serializer #(
        .WORD_W (WORD_W)
    ) u_ser (
        .clk     (prog_clk),
        .rst_n   (pReset_n),
        .clear   (ser_clear),
        .load    (ser_load),
        .word    (bs_data),
        .shift   (shift),
        .bit_out (ser_bit),
        .empty   (ser_empty),
        .last    (ser_last)
    );

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        first_bit_d   = first_bit_q;
        bs_ready      = 1'b0;
        ser_clear     = 1'b0;
        ser_load      = 1'b0;
        ser_busy_next = 1'b0;

        // No word is taken in the cycle that completes the chain.
        if ((state_q == ST_LOAD) && !(shift && (cnt_q == CNT_LAST))) begin
            bs_ready = ser_empty || (ser_last && shift);
        end

        if (shift) begin
            if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            if (cnt_q == '0) begin
                first_bit_d = ser_bit;
            end
        end

        case (state_q)
            ST_IDLE, ST_DONE, ST_FAIL: begin
                if (start) begin
                    state_d   = ST_LOAD;
                    cnt_d     = '0;
                    ser_clear = 1'b1;
                end
            end
            ST_LOAD: begin
                if (shift && (cnt_q == CNT_LAST)) begin
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                state_d = (ccff_tail == first_bit_q) ? ST_DONE : ST_FAIL;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (abort) begin
            state_d   = ST_IDLE;
            cnt_d     = '0;
            ser_clear = 1'b1;
        end

        ser_load      = bs_valid && bs_ready && !ser_clear;
        ser_busy_next = !ser_clear && (ser_load || (!ser_empty && !(shift && ser_last)));

        prog_clk_en_d   = (state_d == ST_LOAD) && ser_busy_next;
        config_enable_d = (state_d == ST_LOAD);
        busy_d          = (state_d == ST_LOAD) || (state_d == ST_CHECK);
        done_d          = (state_d == ST_DONE);
        fail_d          = (state_d == ST_FAIL);
    end

    always_ff @(posedge prog_clk or negedge pReset_n) begin
        if (!pReset_n) begin
            state_q         <= ST_IDLE;
            cnt_q           <= '0;
            first_bit_q     <= 1'b0;
            prog_clk_en_q   <= 1'b0;
            config_enable_q <= 1'b0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            fail_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            first_bit_q     <= first_bit_d;
            prog_clk_en_q   <= prog_clk_en_d;
            config_enable_q <= config_enable_d;
            busy_q          <= busy_d;
            done_q          <= done_d;
            fail_q          <= fail_d;
        end
    end

    assign ccff_head     = ser_bit;
    assign prog_clk_en   = prog_clk_en_q;
    assign config_enable = config_enable_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign fail          = fail_q;

endmodule

// File: doc/ccff_chain_loader.md
# ccff_chain_loader

Bitstream loader that drives the configuration-chain head (`ccff_head`) of the fabric's scan chain of configuration flip-flops (ccff) and watches its `ccff_tail`. It is the writer for the `ccff_head` → `ccff_tail` protocol used by every grid and routing tile. It accepts bitstream words over a valid/ready stream and serializes them MSB-first. It asserts `config_enable` and gates the chain shift so that no bit is lost when the stream stalls. It flags an error if the first loaded bit does not reach `ccff_tail` after exactly `CHAIN_LEN` shifts.

## Interface
- `WORD_W`, 32, width of input bitstream words (≥2).
- `CHAIN_LEN`, 1024, total ccff bits in the chain (≥2).
- `CNT_W`, $clog2(CHAIN_LEN+1), shift counter width (derived, not overridden).

Ports:
- `prog_clk` input 1: programming clock; the only clock.
- `pReset_n` input 1: reset, asynchronous assert, active-low.
- `start` input 1: one-cycle pulse; begins a load; ignored unless IDLE, DONE or FAIL.
- `abort` input 1: returns to IDLE next cycle from any state.
- `bs_data` input WORD_W: bitstream word, MSB shifted first.
- `bs_valid` input 1: `bs_data` valid.
- `bs_ready` output 1: word accepted when `bs_valid && bs_ready`.
- `ccff_head` output 1: serial data to chain head.
- `ccff_tail` input 1: serial data from chain tail.
- `prog_clk_en` output 1: chain shift enable for the integrated clock gate (ICG) on the chain clock; one chain shift per cycle it is high.
- `config_enable` output 1: high while the chain is being loaded.
- `busy` output 1: state is LOAD or CHECK.
- `done` output 1: load completed, tail check passed (level, held).
- `fail` output 1: tail check failed (level, held).

## Operation
- States: IDLE, LOAD, CHECK, DONE, FAIL.
- IDLE/DONE/FAIL + `start`:
  - go to LOAD;
  - clear shift counter `cnt`, `done` and `fail`;
  - shift register empty.
- LOAD:
  - `bs_ready` = 1 only when the shift register is empty, or holds its last bit and that bit is shifting this cycle (back-to-back words give no bubble).
  - The accepted word loads into the shift register with a bit index of WORD_W-1.
  - Each cycle the shift register holds a bit:
    - `ccff_head` = current bit, `prog_clk_en` = 1, `cnt` increments;
    - the bit index decrements; the register empties after bit 0.
  - The first shifted bit is captured into `first_bit`.
  - Empty shift register (underrun): `prog_clk_en` = 0; `ccff_head` holds its last value; `cnt` holds.
  - When `cnt` reaches CHAIN_LEN:
    - go to CHECK;
    - unshifted bits of the current word are discarded;
    - no further words are accepted.
- CHECK (one cycle):
  - `ccff_tail` == `first_bit` → DONE, else → FAIL.
  - `prog_clk_en` = 0, `config_enable` = 0.
- DONE/FAIL: hold until `start` or `abort`.
- `abort`:
  - IDLE next cycle; `prog_clk_en` = 0 from that cycle.
  - Chain contents are undefined and `done`/`fail` are cleared.
  - `abort` has priority over `start` and over the LOAD→CHECK transition.
- `config_enable` = 1 exactly in LOAD.
- Arithmetic:
  - `cnt` saturates at CHAIN_LEN and never wraps.
  - The bit index is $clog2(WORD_W) bits wide.

## Timing
- All outputs are registered except `bs_ready`, which is combinational from state, bit index and `cnt`.
- Reset values:
  - state IDLE;
  - `ccff_head` = 0, `prog_clk_en` = 0, `config_enable` = 0;
  - `bs_ready` = 0, `busy` = 0, `done` = 0, `fail` = 0.
- `start` at edge N:
  - LOAD and `config_enable` = 1 from cycle N+1;
  - `bs_ready` may be 1 in cycle N+1;
  - the first accepted word in cycle M gives its first bit on `ccff_head` with `prog_clk_en` = 1 in cycle M+1.
- The chain captures `ccff_head` at the `prog_clk` edge that ends a cycle with `prog_clk_en` = 1.
- Minimum load time with no stalls: 1 + CHAIN_LEN + 1 cycles from `start` to CHECK; `done`/`fail` visible one cycle after CHECK.
- Reset asserted mid-load: all outputs go to reset values immediately; no shift occurs while in reset.

## Structure
- Shared package `ccff_pkg`:
  - state enum `ccff_ld_state_t` (IDLE, LOAD, CHECK, DONE, FAIL);
  - default localparams for WORD_W and CHAIN_LEN, so tile generators and the loader agree.
- One sub-module, `ccff_word_serializer`:
  - holds the word register, bit index and empty flag;
  - ports: load, word, shift, bit_out, empty, last.
- The top holds the FSM, `cnt`, `first_bit` and the output registers.

## Test plan
- WORD_W=4, CHAIN_LEN=10, model chain = 10-bit shift register clocked when `prog_clk_en`=1.
  - Stimulus: words 0xA, 0x5, 0xC, `bs_valid` held.
  - Required: 10 consecutive `prog_clk_en` cycles; chain holds 1010010111 (first bit at tail); `done`=1; `bs_ready` never high after the 3rd accept.
- Same setup, `bs_valid` dropped 3 cycles between words 1 and 2.
  - Required: `prog_clk_en`=0 for exactly those 3 cycles; final chain identical; `done`=1.
- Model chain of length 9 (one short) with CHAIN_LEN=10 and first bit 1 followed by 0.
  - Required: `fail`=1, `done`=0.
- `abort` asserted after the 5th shift.
  - Required: next cycle IDLE, `prog_clk_en`=0, `config_enable`=0.
  - Then a new `start` with the same words gives `done`=1.
- `pReset_n` low mid-LOAD.
  - Required: immediate reset values; no chain shift while low.
  - After release, `start` performs a full correct load.
- `start` pulsed during LOAD.
  - Required: ignored; shift count and result unchanged.
